seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Multiplexed 7-segment scan controller that sits directly upstream of the shift-register serializer. It snapshots a multi-digit hex value and decodes one digit at a time into a word of one-hot digit select plus DP and segment bits. Each word is offered to the serializer over a valid/ready handshake, then the digit is held for a programmable dwell time before the next digit is offered. One set of daisy-chained shift registers can therefore drive an N-digit common-cathode or common-anode display.

Parameters:
NUM_DIGITS, 4, number of display digits; must be at least 1.
DWELL_CYCLES, 4096, i_clk cycles a digit is held after acceptance; must be at least 1.
SEG_ACTIVE_LOW, 0, when 1, the DP and segment bits of o_word are inverted; digit select bits are never inverted.

Ports:
i_clk  input  1  system clock.
i_reset_n  input  1  asynchronous, active-low reset.
i_value  input  4*NUM_DIGITS  hex digits; bits [3:0] are digit 0, the least significant digit.
i_dp_mask  input  NUM_DIGITS  decimal point enable per digit.
i_blank_leading  input  1  enables leading-zero blanking.
o_word_valid  output  1  o_word is offered to the serializer.
i_word_ready  input  1  serializer accepts o_word.
o_word  output  NUM_DIGITS+8  {digit_sel one-hot, dp, seg[6:0]}; seg bit order is g f e d c b a (bit0 = a).
o_digit_idx  output  $clog2(NUM_DIGITS), minimum 1  index of the digit currently offered or held.
o_frame_done  output  1  one-cycle pulse each time the last digit's dwell completes.

Behaviour:
- Reset, asserted asynchronously: state=LOAD, o_word_valid=0, o_word=0, o_digit_idx=0, o_frame_done=0, dwell counter=0, snapshot=0.
- Reset asserted mid-operation: all of the above takes effect immediately. Any in-flight word is dropped and no handshake completes.
- State LOAD (one cycle):
  - If o_digit_idx==0, capture i_value and i_dp_mask into the snapshot. The word is decoded from the value captured in this same cycle.
  - Register o_word from the snapshot for o_digit_idx. Set o_word_valid=1 and move to OFFER.
- State OFFER:
  - o_word_valid=1, and o_word is held stable until the handshake completes.
  - Handshake = o_word_valid && i_word_ready at a rising edge.
  - On handshake: o_word_valid<=0, counter<=DWELL_CYCLES-1, move to DWELL. o_word keeps its last value.
- State DWELL:
  - While counter!=0, decrement it.
  - When counter==0: move to LOAD and advance o_digit_idx. At NUM_DIGITS-1 it wraps to 0, and o_frame_done<=1 for exactly one cycle, the LOAD cycle of digit 0.
- Timing:
  - The first o_word_valid rises on the second rising edge after i_reset_n deasserts; the first edge executes LOAD.
  - With a handshake at edge t, the next o_word_valid rises at edge t+DWELL_CYCLES+2.
- Decode is standard hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- digit_sel = 1<<o_digit_idx.
- dp = snapshot dp_mask[o_digit_idx].
- Leading-zero blanking: when i_blank_leading=1, a digit is blanked (seg=0) if it and every more-significant digit are 0. Digit 0 is never blanked, and the dp bit is unaffected by blanking.
- SEG_ACTIVE_LOW inverts dp and seg after blanking, so a blanked digit emits seg=7F.
- i_word_ready while o_word_valid=0 is ignored.
- Changes to i_value or i_dp_mask mid-frame do not affect the remaining digits of that frame.

Test Plan:
- Defaults except DWELL_CYCLES=3; i_value=16'h12AF, ready tied 1, dp=0, blank=0 -> o_word sequence 0x171, 0x277, 0x45B, 0x806, repeating. Each valid is high 1 cycle, with 5 edges between valid pulses. o_frame_done pulses once per 4 words.
- i_value=16'h0050, blank=1 -> words 0x13F, 0x26D, 0x400, 0x800. With blank=0 -> 0x13F, 0x26D, 0x43F, 0x83F.
- Backpressure: hold ready=0 for 5 cycles while valid=1 -> valid and o_word stay constant and o_digit_idx does not advance. The word is accepted on the first ready=1 edge.
- Snapshot: change i_value from 16'h12AF to 16'hFFFF after digit 1 is accepted -> digits 2 and 3 still emit 0x45B and 0x806. The next frame emits 0x171-style F words (0x171, 0x271, 0x471, 0x871).
- SEG_ACTIVE_LOW=1, i_value=16'h000F, dp_mask=4'b0001, blank=1 -> digit 0 emits 0x10E and digit 1 emits 0x2FF.
- Drop i_reset_n during OFFER of digit 2 -> valid=0, o_word=0, o_digit_idx=0 immediately. After release, the first word is digit 0 on the second edge.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: snapshots a hex value, decodes one digit at a
// time into {digit_sel, dp, seg} words and offers each word over valid/ready, then dwells.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DWELL_CYCLES   = 4096,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp_mask,
    input  logic                    i_blank_leading,
    output logic                    o_word_valid,
    input  logic                    i_word_ready,
    output logic [NUM_DIGITS+7:0]   o_word,
    output logic [IDX_W-1:0]        o_digit_idx,
    output logic                    o_frame_done
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    valid_q, valid_d;
    logic [NUM_DIGITS+7:0]   word_q, word_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    done_q, done_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;

    // Digit 0 decodes from the value being captured in the same cycle, so bypass the snapshot.
    logic                    first_digit;
    logic [4*NUM_DIGITS-1:0] val_use;
    logic [NUM_DIGITS-1:0]   dp_use;
    assign first_digit = (idx_q == '0);
    assign val_use     = first_digit ? i_value   : snap_val_q;
    assign dp_use      = first_digit ? i_dp_mask : snap_dp_q;

    // zero_from[k] is set when digit k and every more-significant digit are zero.
    logic [NUM_DIGITS-1:0] digit_nz;
    logic [NUM_DIGITS-1:0] zero_from;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_nz[gi]  = |val_use[4*gi +: 4];
            assign zero_from[gi] = ~|(digit_nz >> gi);
        end
    endgenerate

    logic [3:0]            nibble;
    logic [6:0]            seg_raw;
    logic                  blank;
    logic [7:0]            dp_seg;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [NUM_DIGITS+7:0] word_new;

    assign nibble    = val_use[4*idx_q +: 4];
    assign blank     = i_blank_leading && !first_digit && zero_from[idx_q];
    assign digit_sel = NUM_DIGITS'(1) << idx_q;

    always_comb begin
        seg_raw = 7'h00;
        case (nibble)
            4'h0: seg_raw = 7'h3F;
            4'h1: seg_raw = 7'h06;
            4'h2: seg_raw = 7'h5B;
            4'h3: seg_raw = 7'h4F;
            4'h4: seg_raw = 7'h66;
            4'h5: seg_raw = 7'h6D;
            4'h6: seg_raw = 7'h7D;
            4'h7: seg_raw = 7'h07;
            4'h8: seg_raw = 7'h7F;
            4'h9: seg_raw = 7'h6F;
            4'hA: seg_raw = 7'h77;
            4'hB: seg_raw = 7'h7C;
            4'hC: seg_raw = 7'h39;
            4'hD: seg_raw = 7'h5E;
            4'hE: seg_raw = 7'h79;
            4'hF: seg_raw = 7'h71;
            default: seg_raw = 7'h00;
        endcase
    end

    // Inversion applies after blanking, so a blanked digit drives all segments inactive.
    always_comb begin
        dp_seg = {dp_use[idx_q], blank ? 7'h00 : seg_raw};
        if (SEG_ACTIVE_LOW) begin
            dp_seg = ~dp_seg;
        end
        word_new = {digit_sel, dp_seg};
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        word_d     = word_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        snap_val_d = snap_val_q;
        snap_dp_d  = snap_dp_q;
        case (state_q)
            ST_LOAD: begin
                if (first_digit) begin
                    snap_val_d = i_value;
                    snap_dp_d  = i_dp_mask;
                end
                word_d  = word_new;
                valid_d = 1'b1;
                state_d = ST_OFFER;
            end
            ST_OFFER: begin
                if (i_word_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = CNT_W'(DWELL_CYCLES - 1);
                    state_d = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_LOAD;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_LOAD;
            valid_q    <= 1'b0;
            word_q     <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
        end
    end

    assign o_word_valid = valid_q;
    assign o_word       = word_q;
    assign o_digit_idx  = idx_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a transaction-level timing/decode model checked every
// cycle against an active-high and an active-low instance, plus literal word-sequence checks.
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h12AF;
    logic [3:0]  dp = 4'h0;
    logic        blank = 1'b0;
    logic        ready = 1'b1;

    logic        v0, v1, done0, done1;
    logic [11:0] w0, w1;
    logic [1:0]  idx0, idx1;

    seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_dp_mask(dp),
        .i_blank_leading(blank), .o_word_valid(v0), .i_word_ready(ready),
        .o_word(w0), .o_digit_idx(idx0), .o_frame_done(done0)
    );

    seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_dp_mask(dp),
        .i_blank_leading(blank), .o_word_valid(v1), .i_word_ready(ready),
        .o_word(w1), .o_digit_idx(idx1), .o_frame_done(done1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [11:0] expect_word(input logic [15:0] v, input logic [3:0] dpm,
                                                input logic bl, input int i);
        logic [3:0] nib;
        logic       blanked;
        nib     = v[4*i +: 4];
        blanked = bl && (i != 0) && ((v >> (4*i)) == 16'h0);
        return {4'(1 << i), dpm[i], blanked ? 7'h00 : seg_tab[nib]};
    endfunction

    // Model: after an acceptance the line is idle for D+1 edges; the digit index moves one edge
    // before the next offer, and the frame pulse marks wrapping back to digit 0.
    logic        m_valid, m_done, m_loaded, m_adv;
    logic [11:0] m_word;
    logic [15:0] m_snap_val;
    logic [3:0]  m_snap_dp;
    int          m_idx, m_gap, cyc;

    logic [11:0] acc0[$];
    logic [11:0] acc1[$];
    int          acc_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst_n && v0 && ready) begin
            acc0.push_back(w0);
            acc1.push_back(w1);
            acc_cyc.push_back(cyc);
            $display("accept t=%0d idx=%0d word0=%03h word1=%03h", cyc, idx0, w0, w1);
        end
        if (!rst_n) begin
            m_valid = 0; m_done = 0; m_loaded = 0; m_adv = 0;
            m_word = '0; m_idx = 0; m_gap = 1;
            m_snap_val = '0; m_snap_dp = '0;
        end else begin
            m_done = 0;
            if (m_valid) begin
                if (ready) begin
                    m_valid = 0;
                    m_gap   = D + 1;
                    m_adv   = 1;
                end
            end else begin
                m_gap--;
                if (m_gap == 1 && m_adv) begin
                    m_adv  = 0;
                    m_idx  = (m_idx + 1) % N;
                    m_done = (m_idx == 0);
                end
                if (m_gap == 0) begin
                    if (m_idx == 0) begin
                        m_snap_val = value;
                        m_snap_dp  = dp;
                    end
                    m_word   = expect_word(m_snap_val, m_snap_dp, blank, m_idx);
                    m_valid  = 1;
                    m_loaded = 1;
                end
            end
        end
        #1;
        chk("valid0", 32'(v0), 32'(m_valid));
        chk("word0", 32'(w0), 32'(m_word));
        chk("idx0", 32'(idx0), 32'(m_idx));
        chk("done0", 32'(done0), 32'(m_done));
        chk("valid1", 32'(v1), 32'(m_valid));
        chk("word1", 32'(w1), m_loaded ? 32'({m_word[11:8], ~m_word[7:0]}) : 32'h0);
        chk("idx1", 32'(idx1), 32'(m_idx));
        chk("done1", 32'(done1), 32'(m_done));
    end

    task automatic clear_acc();
        acc0.delete();
        acc1.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!done0) chk({name, "_done_timeout"}, 32'(done0), 32'h1);
        clear_acc();
    endtask

    task automatic wait_acc(input int cnt, input string name);
        int n = 0;
        while (acc0.size() < cnt && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (acc0.size() < cnt) begin
            chk({name, "_acc_timeout"}, 32'(acc0.size()), 32'(cnt));
            while (acc0.size() < cnt) acc0.push_back('x);
            while (acc1.size() < cnt) acc1.push_back('x);
        end
    endtask

    task automatic collect(input string name, input bit wait_frame,
                           input logic [11:0] e0, input logic [11:0] e1,
                           input logic [11:0] e2, input logic [11:0] e3);
        if (wait_frame) wait_done(name);
        wait_acc(4, name);
        chk({name, "_d0"}, 32'(acc0[0]), 32'(e0));
        chk({name, "_d1"}, 32'(acc0[1]), 32'(e1));
        chk({name, "_d2"}, 32'(acc0[2]), 32'(e2));
        chk({name, "_d3"}, 32'(acc0[3]), 32'(e3));
    endtask

    initial begin
        logic [11:0] held_word;
        logic [1:0]  held_idx;
        int          n;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(v0), 32'h0);
        chk("rst_word", 32'(w0), 32'h0);
        chk("rst_idx", 32'(idx0), 32'h0);
        clear_acc();
        rst_n = 1'b1;

        // Basic frame straight after reset, with the valid-to-valid spacing of D+2 edges.
        collect("hex12af", 1'b0, 12'h171, 12'h277, 12'h45B, 12'h806);
        for (int i = 1; i < 4; i++) chk("spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(D + 2));
        collect("hex12af_rep", 1'b1, 12'h171, 12'h277, 12'h45B, 12'h806);

        value = 16'h0050; blank = 1'b1;
        collect("blank_on", 1'b1, 12'h13F, 12'h26D, 12'h400, 12'h800);
        blank = 1'b0;
        collect("blank_off", 1'b1, 12'h13F, 12'h26D, 12'h43F, 12'h83F);

        // Backpressure: the offered word and index must hold until ready returns.
        value = 16'h12AF;
        @(negedge clk);
        ready = 1'b0;
        n = 0;
        while (!v0 && n < 100) begin @(negedge clk); n++; end
        chk("bp_valid_seen", 32'(v0), 32'h1);
        held_word = w0;
        held_idx  = idx0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(v0), 32'h1);
            chk("bp_word", 32'(w0), 32'(held_word));
            chk("bp_idx", 32'(idx0), 32'(held_idx));
        end
        ready = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_accept", 32'(v0), 32'h0);

        // Snapshot: a value change after digit 1 must not reach digits 2 and 3.
        wait_done("snap");
        wait_acc(2, "snap");
        value = 16'hFFFF;
        wait_acc(4, "snap");
        chk("snap_d2", 32'(acc0[2]), 32'h45B);
        chk("snap_d3", 32'(acc0[3]), 32'h806);
        collect("snap_next", 1'b1, 12'h171, 12'h271, 12'h471, 12'h871);

        // Active-low instance with dp and blanking.
        value = 16'h000F; dp = 4'b0001; blank = 1'b1;
        wait_done("actlow");
        wait_acc(2, "actlow");
        chk("actlow_d0", 32'(acc1[0]), 32'h10E);
        chk("actlow_d1", 32'(acc1[1]), 32'h2FF);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                value = 16'($urandom);
                if ($urandom_range(0, 1) == 0) value = value >> (4 * $urandom_range(1, 3));
                dp    = 4'($urandom);
                blank = 1'($urandom);
            end
        end

        // Asynchronous reset while digit 2 is being offered.
        ready = 1'b1; value = 16'h12AF; dp = 4'h0; blank = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(v0 && idx0 == 2'd2) && n < 500) begin @(negedge clk); n++; end
        chk("mid_offer_seen", 32'(v0 && idx0 == 2'd2), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(v0), 32'h0);
        chk("arst_word", 32'(w0), 32'h0);
        chk("arst_idx", 32'(idx0), 32'h0);
        chk("arst_word1", 32'(w1), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("post_rst_valid", 32'(v0), 32'h1);
        chk("post_rst_word", 32'(w0), 32'h171);

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
